// File: rtl/fetch_redirect_unit.sv
// ---------------------------------------------------------------------------
// fetch_redirect_unit
//   Fetch stage plus IF/ID pipeline register. Owns the PC, addresses a
//   synchronous-read instruction memory and fills IF/ID. A taken branch
//   (Flush) redirects the PC to the resolved target and squashes the one
//   wrong-path word that is already in flight. A load-use stall freezes the
//   stage. Accepted redirects are counted in a saturating counter.
//
// Ports
//   clk           in   1       clock, all state on rising edge
//   reset         in   1       asynchronous reset, active low
//   stall         in   1       hold PC and IF/ID this cycle
//   Flush         in   1       taken branch: redirect this cycle (beats stall)
//   branch_target in   ADDR_W  redirect target, used only while Flush=1
//   inst_in       in   INST_W  imem read data for last cycle's pc_out
//   pc_out        out  ADDR_W  imem read address (the PC register)
//   if_id_pc      out  ADDR_W  IF/ID: PC of held instruction
//   if_id_inst    out  INST_W  IF/ID: instruction, NOP_INST when invalid
//   if_id_valid   out  1       IF/ID: real correct-path instruction
//   flush_count   out  CNT_W   accepted redirects, saturating
// ---------------------------------------------------------------------------
module fetch_redirect_unit #(
  parameter int unsigned        ADDR_W   = 64,
  parameter int unsigned        INST_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = 64'h0,
  parameter logic [INST_W-1:0]  NOP_INST = 32'h0000_0013,
  parameter int unsigned        CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              Flush,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [INST_W-1:0] inst_in,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [INST_W-1:0] if_id_inst,
  output logic              if_id_valid,
  output logic [CNT_W-1:0]  flush_count
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } state_t;

  // Saturating increment for the redirect counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_fetch_pc;
  logic [ADDR_W-1:0]   r_if_id_pc;
  logic [INST_W-1:0]   r_if_id_inst;
  logic                r_if_id_valid;
  logic [CNT_W-1:0]    r_flush_count;
  // The imem keeps reading pc_out during a stall, so the word that belongs to
  // r_fetch_pc would be overwritten by the next address's data. It is parked
  // here on the first stall cycle and consumed on the following advance.
  logic [INST_W-1:0]   r_hold_inst;
  logic                r_hold_valid;

  logic [ADDR_W-1:0]   w_pc;
  logic [ADDR_W-1:0]   w_fetch_pc;
  logic [ADDR_W-1:0]   w_if_id_pc;
  logic [INST_W-1:0]   w_if_id_inst;
  logic                w_if_id_valid;
  logic [CNT_W-1:0]    w_flush_count;
  logic [INST_W-1:0]   w_hold_inst;
  logic                w_hold_valid;
  logic [INST_W-1:0]   w_fetch_word;
  logic [ADDR_W-1:0]   w_redirect_pc;

  // Word that belongs to r_fetch_pc: the parked copy if a stall intervened.
  assign w_fetch_word  = r_hold_valid ? r_hold_inst : inst_in;
  // Targets are forced word-aligned.
  assign w_redirect_pc = branch_target & {{(ADDR_W-2){1'b1}}, 2'b00};

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_SQUASH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and datapath update; Flush beats stall, stall beats advance.
  always_comb begin
    w_next_state  = r_state;
    w_pc          = r_pc;
    w_fetch_pc    = r_fetch_pc;
    w_if_id_pc    = r_if_id_pc;
    w_if_id_inst  = r_if_id_inst;
    w_if_id_valid = r_if_id_valid;
    w_flush_count = r_flush_count;
    w_hold_inst   = r_hold_inst;
    w_hold_valid  = r_hold_valid;
    if (Flush) begin
      w_pc          = w_redirect_pc;
      w_if_id_pc    = {ADDR_W{1'b0}};
      w_if_id_inst  = NOP_INST;
      w_if_id_valid = 1'b0;
      w_hold_valid  = 1'b0;
      w_next_state  = ST_SQUASH;
      w_flush_count = sat_inc(r_flush_count);
    end else if (stall) begin
      // Park the in-flight word only once; later stall cycles keep it.
      if (!r_hold_valid) begin
        w_hold_inst  = inst_in;
        w_hold_valid = 1'b1;
      end else begin
        w_hold_inst  = r_hold_inst;
        w_hold_valid = 1'b1;
      end
    end else begin
      w_pc         = r_pc + {{(ADDR_W-3){1'b0}}, 3'd4};
      w_fetch_pc   = r_pc;
      w_hold_valid = 1'b0;
      case (r_state)
        ST_RUN: begin
          w_if_id_pc    = r_fetch_pc;
          w_if_id_inst  = w_fetch_word;
          w_if_id_valid = 1'b1;
        end
        ST_SQUASH: begin
          // The in-flight word came from a stale PC: drop it once.
          w_if_id_pc    = {ADDR_W{1'b0}};
          w_if_id_inst  = NOP_INST;
          w_if_id_valid = 1'b0;
          w_next_state  = ST_RUN;
        end
        default: begin
          w_if_id_pc    = {ADDR_W{1'b0}};
          w_if_id_inst  = NOP_INST;
          w_if_id_valid = 1'b0;
          w_next_state  = ST_SQUASH;
        end
      endcase
    end
  end

  // PC, fetch address, IF/ID, stall hold buffer and redirect counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc          <= RESET_PC;
      r_fetch_pc    <= RESET_PC;
      r_if_id_pc    <= {ADDR_W{1'b0}};
      r_if_id_inst  <= NOP_INST;
      r_if_id_valid <= 1'b0;
      r_flush_count <= {CNT_W{1'b0}};
      r_hold_inst   <= NOP_INST;
      r_hold_valid  <= 1'b0;
    end else begin
      r_pc          <= w_pc;
      r_fetch_pc    <= w_fetch_pc;
      r_if_id_pc    <= w_if_id_pc;
      r_if_id_inst  <= w_if_id_inst;
      r_if_id_valid <= w_if_id_valid;
      r_flush_count <= w_flush_count;
      r_hold_inst   <= w_hold_inst;
      r_hold_valid  <= w_hold_valid;
    end
  end

  assign pc_out      = r_pc;
  assign if_id_pc    = r_if_id_pc;
  assign if_id_inst  = r_if_id_inst;
  assign if_id_valid = r_if_id_valid;
  assign flush_count = r_flush_count;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_redirect_unit
//   Drives fetch_redirect_unit with directed scenarios and random
//   stall/Flush traffic. The imem is modelled as a synchronous-read memory
//   whose contents are a fixed function of the address. The reference model
//   tracks the PC and a single "word in flight" token (address plus whether
//   it is on the correct path) and predicts IF/ID from it.
// ---------------------------------------------------------------------------
module tb_fetch_redirect_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        Flush;
  logic [63:0] branch_target;
  logic [31:0] inst_in;
  logic [63:0] pc_out;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        if_id_valid;
  logic [15:0] flush_count;

  always #5 clk = ~clk;

  fetch_redirect_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .Flush        (Flush),
    .branch_target(branch_target),
    .inst_in      (inst_in),
    .pc_out       (pc_out),
    .if_id_pc     (if_id_pc),
    .if_id_inst   (if_id_inst),
    .if_id_valid  (if_id_valid),
    .flush_count  (flush_count)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  logic [63:0] m_pc;
  logic [63:0] m_fly;
  logic        m_fly_ok;
  logic [63:0] m_ipc;
  logic [31:0] m_inst;
  logic        m_v;
  logic [15:0] m_cnt;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A3C_0F00;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc     = 64'h0;
    m_fly    = 64'h0;
    m_fly_ok = 1'b0;
    m_ipc    = 64'h0;
    m_inst   = NOP;
    m_v      = 1'b0;
    m_cnt    = 16'h0;
  endtask

  task automatic model_edge(input logic s, input logic f, input logic [63:0] t);
    if (f) begin
      m_pc     = t & ~64'd3;
      m_fly_ok = 1'b0;
      m_ipc    = 64'h0;
      m_inst   = NOP;
      m_v      = 1'b0;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else if (!s) begin
      if (m_fly_ok) begin
        m_ipc  = m_fly;
        m_inst = mem_word(m_fly);
        m_v    = 1'b1;
      end else begin
        m_ipc  = 64'h0;
        m_inst = NOP;
        m_v    = 1'b0;
      end
      m_fly    = m_pc;
      m_fly_ok = 1'b1;
      m_pc     = m_pc + 64'd4;
    end
  endtask

  task automatic check_all();
    chk("pc_out",      pc_out,              m_pc);
    chk("if_id_pc",    if_id_pc,            m_ipc);
    chk("if_id_inst",  {32'h0, if_id_inst}, {32'h0, m_inst});
    chk("if_id_valid", {63'h0, if_id_valid}, {63'h0, m_v});
    chk("flush_count", {48'h0, flush_count}, {48'h0, m_cnt});
  endtask

  // One clock: apply inputs, clock, update model, emulate imem read, compare.
  task automatic step(input logic s, input logic f, input logic [63:0] t);
    logic [63:0] pc_before;
    stall         = s;
    Flush         = f;
    branch_target = f ? t : {$urandom, $urandom};
    pc_before     = pc_out;
    @(posedge clk);
    model_edge(s, f, t);
    #1;
    inst_in = mem_word(pc_before);
    check_all();
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    stall   = 1'b0;
    Flush   = 1'b0;
    inst_in = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [15:0] cnt_save;

  initial begin
    branch_target = 64'h0;
    do_reset();

    // T1: reset release, first valid word at second advance
    step(1'b0, 1'b0, 64'h0);
    chk("t1_bubble_valid", {63'h0, if_id_valid}, 64'h0);
    step(1'b0, 1'b0, 64'h0);
    chk("t1_first_pc",    if_id_pc, 64'h0);
    chk("t1_first_inst",  {32'h0, if_id_inst}, {32'h0, mem_word(64'h0)});
    chk("t1_first_valid", {63'h0, if_id_valid}, 64'h1);
    step(1'b0, 1'b0, 64'h0);
    chk("t1_second_pc",   if_id_pc, 64'h4);
    chk("t1_second_inst", {32'h0, if_id_inst}, {32'h0, mem_word(64'h4)});

    // T2: redirect from pc_out=0x20 to 0x100
    repeat (5) step(1'b0, 1'b0, 64'h0);
    chk("t2_pc_before", pc_out, 64'h20);
    step(1'b0, 1'b1, 64'h100);
    chk("t2_pc_target", pc_out, 64'h100);
    chk("t2_squash0",   {63'h0, if_id_valid}, 64'h0);
    step(1'b0, 1'b0, 64'h0);
    chk("t2_squash1",   {63'h0, if_id_valid}, 64'h0);
    step(1'b0, 1'b0, 64'h0);
    chk("t2_target_pc", if_id_pc, 64'h100);
    chk("t2_target_v",  {63'h0, if_id_valid}, 64'h1);
    chk("t2_count",     {48'h0, flush_count}, 64'h1);

    // T3: three stall cycles at pc_out=0x40
    step(1'b0, 1'b1, 64'h38);
    repeat (2) step(1'b0, 1'b0, 64'h0);
    chk("t3_pc_at_stall", pc_out, 64'h40);
    repeat (3) begin
      step(1'b1, 1'b0, 64'h0);
      chk("t3_frozen_pc",   pc_out, 64'h40);
      chk("t3_frozen_ifid", if_id_pc, 64'h38);
    end
    step(1'b0, 1'b0, 64'h0);
    chk("t3_resume_pc",   pc_out, 64'h44);
    chk("t3_resume_ifid", if_id_pc, 64'h3C);
    chk("t3_resume_inst", {32'h0, if_id_inst}, {32'h0, mem_word(64'h3C)});
    step(1'b0, 1'b0, 64'h0);
    chk("t3_next_ifid",   if_id_pc, 64'h40);

    // T4: Flush beats stall; re-redirect while squashing
    cnt_save = flush_count;
    step(1'b1, 1'b1, 64'h203);
    chk("t4_pc_aligned", pc_out, 64'h200);
    step(1'b0, 1'b1, 64'h300);
    chk("t4_pc_second",  pc_out, 64'h300);
    chk("t4_count_plus2", {48'h0, flush_count}, {48'h0, cnt_save + 16'd2});
    repeat (3) step(1'b0, 1'b0, 64'h0);
    chk("t4_ifid_target", if_id_pc, 64'h304);

    // T5: PC wrap and counter saturation
    step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b0, 1'b0, 64'h0);
    chk("t5_wrap", pc_out, 64'h0);
    step(1'b0, 1'b0, 64'h0);
    chk("t5_wrap_ifid", if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    for (int i = 0; i < 65540; i++) begin
      step(($urandom_range(0, 1) == 0), 1'b1, {$urandom, $urandom});
    end
    chk("t5_saturated", {48'h0, flush_count}, 64'hFFFF);

    // T6: asynchronous reset between edges while squashing
    step(1'b0, 1'b1, 64'h500);
    #3;
    reset = 1'b0;
    #1;
    chk("t6_pc",    pc_out, 64'h0);
    chk("t6_valid", {63'h0, if_id_valid}, 64'h0);
    chk("t6_inst",  {32'h0, if_id_inst}, {32'h0, NOP});
    chk("t6_count", {48'h0, flush_count}, 64'h0);
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b0, 64'h0);
    chk("t6_restart_pc", if_id_pc, 64'h0);
    chk("t6_restart_v",  {63'h0, if_id_valid}, 64'h1);

    // Random stall/Flush traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), {$urandom, $urandom});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
